// File: rtl/pipe_pkg.sv
// Shared types for the ID->EX->WB stage register: occupancy encoding and bubble control value.
package pipe_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Replicated to the control width; an all-zero control word carries no write enables.
    localparam logic CTRL_BUBBLE = 1'b0;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready beat channel carrying a data bundle and a control bundle.
// The master drives valid/data/ctrl and the slave returns ready.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input ready);
    modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter: +1 per cycle with inc high, sticks at all-ones.
// Cleared only by rst_n.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with flush, bubble-zeroed control and stall counter; 1-cycle latency.
// SKID=1 adds a second entry so in_ready comes from a flop; SKID=0 passes out_ready through.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 16,
    parameter bit SKID   = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    pipe_stage_reg_if.slave   up,
    pipe_stage_reg_if.master  dn,
    output logic [1:0]        occ,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              out_vld;
    logic [DATA_W-1:0] head_dat;
    logic [CTRL_W-1:0] head_ctl;

    generate
        if (SKID) begin : g_skid
            occ_e              occ_q, occ_d;
            logic              in_rdy_q;
            logic [DATA_W-1:0] skid_dat;
            logic [CTRL_W-1:0] skid_ctl;
            logic              in_fire, out_fire;
            logic              ld_head_in, ld_skid_in, ld_head_skid;

            assign in_fire  = up.valid & in_rdy_q;
            assign out_fire = (occ_q != OCC_EMPTY) & dn.ready;

            always_comb begin
                occ_d        = occ_q;
                ld_head_in   = 1'b0;
                ld_skid_in   = 1'b0;
                ld_head_skid = 1'b0;
                case (occ_q)
                    OCC_EMPTY: begin
                        if (in_fire) begin
                            occ_d      = OCC_ONE;
                            ld_head_in = 1'b1;
                        end
                    end
                    OCC_ONE: begin
                        if (in_fire && !out_fire) begin
                            occ_d      = OCC_FULL;
                            ld_skid_in = 1'b1;
                        end else if (in_fire && out_fire) begin
                            ld_head_in = 1'b1;
                        end else if (out_fire) begin
                            occ_d = OCC_EMPTY;
                        end
                    end
                    OCC_FULL: begin
                        if (out_fire) begin
                            occ_d        = OCC_ONE;
                            ld_head_skid = 1'b1;
                        end
                    end
                    default: occ_d = OCC_EMPTY;
                endcase
                // A beat accepted in the flush cycle is dropped along with held ones.
                if (flush) begin
                    occ_d        = OCC_EMPTY;
                    ld_head_in   = 1'b0;
                    ld_skid_in   = 1'b0;
                    ld_head_skid = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    occ_q    <= OCC_EMPTY;
                    in_rdy_q <= 1'b1;
                    head_dat <= '0;
                    head_ctl <= '0;
                    skid_dat <= '0;
                    skid_ctl <= '0;
                end else begin
                    occ_q    <= occ_d;
                    in_rdy_q <= (occ_d != OCC_FULL);
                    if (ld_head_in) begin
                        head_dat <= up.data;
                        head_ctl <= up.ctrl;
                    end else if (ld_head_skid) begin
                        head_dat <= skid_dat;
                        head_ctl <= skid_ctl;
                    end
                    if (ld_skid_in) begin
                        skid_dat <= up.data;
                        skid_ctl <= up.ctrl;
                    end
                end
            end

            assign up.ready = in_rdy_q;
            assign out_vld  = (occ_q != OCC_EMPTY);
            assign occ      = occ_q;
        end else begin : g_single
            logic vld_q;
            logic in_rdy, in_fire, out_fire;

            assign in_rdy   = ~vld_q | dn.ready;
            assign in_fire  = up.valid & in_rdy;
            assign out_fire = vld_q & dn.ready;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_q    <= 1'b0;
                    head_dat <= '0;
                    head_ctl <= '0;
                end else begin
                    if (flush) begin
                        vld_q <= 1'b0;
                    end else if (in_fire) begin
                        vld_q <= 1'b1;
                    end else if (out_fire) begin
                        vld_q <= 1'b0;
                    end
                    if (in_fire) begin
                        head_dat <= up.data;
                        head_ctl <= up.ctrl;
                    end
                end
            end

            assign up.ready = in_rdy;
            assign out_vld  = vld_q;
            assign occ      = {1'b0, vld_q};
        end
    endgenerate

    assign dn.valid = out_vld;
    assign dn.data  = head_dat;
    assign dn.ctrl  = out_vld ? head_ctl : {CTRL_W{CTRL_BUBBLE}};

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_vld & ~dn.ready),
        .cnt   (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid mode (a), single-register mode (b),
// and a 4-bit stall counter instance (c) for saturation.
module tb_pipe_stage_reg;

    localparam int DW = 96;
    localparam int CW = 16;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [1:0]  a_occ, b_occ, c_occ;
    logic [15:0] a_cnt, b_cnt;
    logic [3:0]  c_cnt;
    int          cmps;
    int          errs;

    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) a_up ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) a_dn ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) b_up ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) b_dn ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) c_up ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) c_dn ();

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .up(a_up), .dn(a_dn), .occ(a_occ), .stall_cnt(a_cnt));
    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .up(b_up), .dn(b_dn), .occ(b_occ), .stall_cnt(b_cnt));
    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1), .CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .up(c_up), .dn(c_dn), .occ(c_occ), .stall_cnt(c_cnt));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] dat_of(input logic [7:0] v);
        return {v, {10{8'h3C}}, v};
    endfunction

    function automatic logic [CW-1:0] ctl_of(input logic [7:0] v);
        return {8'hA5, v};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] v);
        a_up.valid = 1'b1;
        a_up.data  = dat_of(v);
        a_up.ctrl  = ctl_of(v);
    endtask

    task automatic test_reset();
        repeat (2) tick();
        cmps++; if (a_dn.valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%0h exp=0", a_dn.valid); end
        cmps++; if (a_occ !== 2'd0) begin errs++; $display("FAIL reset_occ got=%0d exp=0", a_occ); end
        cmps++; if (a_dn.ctrl !== '0) begin errs++; $display("FAIL reset_out_ctrl got=%0h exp=0", a_dn.ctrl); end
        cmps++; if (a_dn.data !== '0) begin errs++; $display("FAIL reset_out_data got=%0h exp=0", a_dn.data); end
        cmps++; if (a_up.ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got=%0h exp=1", a_up.ready); end
        cmps++; if (a_cnt !== 16'd0) begin errs++; $display("FAIL reset_stall_cnt got=%0d exp=0", a_cnt); end
        cmps++; if (b_up.ready !== 1'b1) begin errs++; $display("FAIL reset_b_in_ready got=%0h exp=1", b_up.ready); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stream();
        a_dn.ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            send_a(8'(i));
            tick();
            cmps++; if (a_dn.valid !== 1'b1) begin errs++; $display("FAIL stream_valid beat=%0d got=%0h exp=1", i, a_dn.valid); end
            cmps++; if (a_dn.data !== dat_of(8'(i))) begin errs++; $display("FAIL stream_data beat=%0d got=%0h exp=%0h", i, a_dn.data, dat_of(8'(i))); end
            cmps++; if (a_dn.ctrl !== ctl_of(8'(i))) begin errs++; $display("FAIL stream_ctrl beat=%0d got=%0h exp=%0h", i, a_dn.ctrl, ctl_of(8'(i))); end
            cmps++; if (a_up.ready !== 1'b1) begin errs++; $display("FAIL stream_in_ready beat=%0d got=%0h exp=1", i, a_up.ready); end
        end
        a_up.valid = 1'b0;
        tick();
        cmps++; if (a_dn.valid !== 1'b0) begin errs++; $display("FAIL stream_drain_valid got=%0h exp=0", a_dn.valid); end
        cmps++; if (a_dn.ctrl !== '0) begin errs++; $display("FAIL stream_bubble_ctrl got=%0h exp=0", a_dn.ctrl); end
        cmps++; if (a_occ !== 2'd0) begin errs++; $display("FAIL stream_drain_occ got=%0d exp=0", a_occ); end
    endtask

    task automatic test_stall();
        a_dn.ready = 1'b0;
        send_a(8'h0A);
        tick();
        cmps++; if (a_occ !== 2'd1) begin errs++; $display("FAIL stall_occ1 got=%0d exp=1", a_occ); end
        cmps++; if (a_up.ready !== 1'b1) begin errs++; $display("FAIL stall_ready1 got=%0h exp=1", a_up.ready); end
        send_a(8'h0B);
        tick();
        cmps++; if (a_occ !== 2'd2) begin errs++; $display("FAIL stall_occ2 got=%0d exp=2", a_occ); end
        cmps++; if (a_up.ready !== 1'b0) begin errs++; $display("FAIL stall_ready_full got=%0h exp=0", a_up.ready); end
        cmps++; if (a_dn.data !== dat_of(8'h0A)) begin errs++; $display("FAIL stall_hold_data got=%0h exp=%0h", a_dn.data, dat_of(8'h0A)); end
        cmps++; if (a_cnt !== 16'd1) begin errs++; $display("FAIL stall_cnt1 got=%0d exp=1", a_cnt); end
        send_a(8'h0C);
        tick();
        cmps++; if (a_occ !== 2'd2) begin errs++; $display("FAIL stall_occ_hold got=%0d exp=2", a_occ); end
        cmps++; if (a_up.ready !== 1'b0) begin errs++; $display("FAIL stall_ready_hold got=%0h exp=0", a_up.ready); end
        tick();
        cmps++; if (a_cnt !== 16'd3) begin errs++; $display("FAIL stall_cnt3 got=%0d exp=3", a_cnt); end
        cmps++; if (a_dn.ctrl !== ctl_of(8'h0A)) begin errs++; $display("FAIL stall_hold_ctrl got=%0h exp=%0h", a_dn.ctrl, ctl_of(8'h0A)); end
        a_dn.ready = 1'b1;
        tick();
        cmps++; if (a_dn.data !== dat_of(8'h0B)) begin errs++; $display("FAIL stall_release_b got=%0h exp=%0h", a_dn.data, dat_of(8'h0B)); end
        cmps++; if (a_occ !== 2'd1) begin errs++; $display("FAIL stall_release_occ got=%0d exp=1", a_occ); end
        cmps++; if (a_up.ready !== 1'b1) begin errs++; $display("FAIL stall_release_ready got=%0h exp=1", a_up.ready); end
        tick();
        cmps++; if (a_dn.data !== dat_of(8'h0C)) begin errs++; $display("FAIL stall_release_c got=%0h exp=%0h", a_dn.data, dat_of(8'h0C)); end
        cmps++; if (a_dn.valid !== 1'b1) begin errs++; $display("FAIL stall_release_c_valid got=%0h exp=1", a_dn.valid); end
        a_up.valid = 1'b0;
        tick();
        cmps++; if (a_dn.valid !== 1'b0) begin errs++; $display("FAIL stall_drain_valid got=%0h exp=0", a_dn.valid); end
        cmps++; if (a_cnt !== 16'd3) begin errs++; $display("FAIL stall_cnt_final got=%0d exp=3", a_cnt); end
    endtask

    task automatic test_flush();
        a_dn.ready = 1'b0;
        send_a(8'h11);
        tick();
        send_a(8'h12);
        tick();
        cmps++; if (a_occ !== 2'd2) begin errs++; $display("FAIL flush_pre_occ got=%0d exp=2", a_occ); end
        flush = 1'b1;
        send_a(8'h0D);
        tick();
        cmps++; if (a_dn.valid !== 1'b0) begin errs++; $display("FAIL flush_valid got=%0h exp=0", a_dn.valid); end
        cmps++; if (a_dn.ctrl !== '0) begin errs++; $display("FAIL flush_ctrl got=%0h exp=0", a_dn.ctrl); end
        cmps++; if (a_occ !== 2'd0) begin errs++; $display("FAIL flush_occ got=%0d exp=0", a_occ); end
        cmps++; if (a_up.ready !== 1'b1) begin errs++; $display("FAIL flush_in_ready got=%0h exp=1", a_up.ready); end
        cmps++; if (a_cnt !== 16'd5) begin errs++; $display("FAIL flush_keeps_cnt got=%0d exp=5", a_cnt); end
        flush = 1'b0;
        a_up.valid = 1'b0;
        a_dn.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmps++; if (a_dn.valid !== 1'b0) begin errs++; $display("FAIL flush_no_leak cyc=%0d got=%0h exp=0", i, a_dn.valid); end
        end
        send_a(8'h21);
        tick();
        cmps++; if (a_dn.data !== dat_of(8'h21)) begin errs++; $display("FAIL flush_one_pre got=%0h exp=%0h", a_dn.data, dat_of(8'h21)); end
        flush = 1'b1;
        send_a(8'h0E);
        tick();
        cmps++; if (a_dn.valid !== 1'b0) begin errs++; $display("FAIL flush_drop_accept got=%0h exp=0", a_dn.valid); end
        flush = 1'b0;
        a_up.valid = 1'b0;
        tick();
        cmps++; if (a_dn.valid !== 1'b0) begin errs++; $display("FAIL flush_drop_after got=%0h exp=0", a_dn.valid); end
        cmps++; if (a_cnt !== 16'd5) begin errs++; $display("FAIL flush_cnt_after got=%0d exp=5", a_cnt); end
    endtask

    task automatic test_skid0();
        b_dn.ready = 1'b0;
        b_up.valid = 1'b1;
        b_up.data  = dat_of(8'h31);
        b_up.ctrl  = ctl_of(8'h31);
        tick();
        cmps++; if (b_dn.data !== dat_of(8'h31)) begin errs++; $display("FAIL s0_first got=%0h exp=%0h", b_dn.data, dat_of(8'h31)); end
        cmps++; if (b_up.ready !== 1'b0) begin errs++; $display("FAIL s0_ready_stall got=%0h exp=0", b_up.ready); end
        cmps++; if (b_occ !== 2'd1) begin errs++; $display("FAIL s0_occ got=%0d exp=1", b_occ); end
        b_dn.ready = 1'b1;
        b_up.data  = dat_of(8'h32);
        b_up.ctrl  = ctl_of(8'h32);
        #1;
        cmps++; if (b_up.ready !== 1'b1) begin errs++; $display("FAIL s0_ready_comb got=%0h exp=1", b_up.ready); end
        tick();
        cmps++; if (b_dn.data !== dat_of(8'h32)) begin errs++; $display("FAIL s0_replace got=%0h exp=%0h", b_dn.data, dat_of(8'h32)); end
        cmps++; if (b_dn.valid !== 1'b1) begin errs++; $display("FAIL s0_replace_valid got=%0h exp=1", b_dn.valid); end
        b_up.valid = 1'b0;
        tick();
        cmps++; if (b_dn.valid !== 1'b0) begin errs++; $display("FAIL s0_drain got=%0h exp=0", b_dn.valid); end
        cmps++; if (b_dn.ctrl !== '0) begin errs++; $display("FAIL s0_bubble got=%0h exp=0", b_dn.ctrl); end
        cmps++; if (b_cnt !== 16'd0) begin errs++; $display("FAIL s0_cnt got=%0d exp=0", b_cnt); end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_cnt;
        cmps++; if (c_up.ready !== 1'b1) begin errs++; $display("FAIL sat_ready got=%0h exp=1", c_up.ready); end
        c_dn.ready = 1'b0;
        c_up.valid = 1'b1;
        c_up.data  = dat_of(8'h41);
        c_up.ctrl  = ctl_of(8'h41);
        tick();
        c_up.valid = 1'b0;
        cmps++; if (c_cnt !== 4'd0) begin errs++; $display("FAIL sat_start got=%0d exp=0", c_cnt); end
        for (int k = 2; k <= 24; k++) begin
            tick();
            exp_cnt = (k - 1 > 15) ? 4'd15 : 4'(k - 1);
            cmps++; if (c_cnt !== exp_cnt) begin errs++; $display("FAIL sat_cnt cyc=%0d got=%0d exp=%0d", k, c_cnt, exp_cnt); end
        end
        cmps++; if (c_dn.data !== dat_of(8'h41)) begin errs++; $display("FAIL sat_hold_data got=%0h exp=%0h", c_dn.data, dat_of(8'h41)); end
        cmps++; if (c_dn.ctrl !== ctl_of(8'h41)) begin errs++; $display("FAIL sat_hold_ctrl got=%0h exp=%0h", c_dn.ctrl, ctl_of(8'h41)); end
        cmps++; if (c_occ !== 2'd1) begin errs++; $display("FAIL sat_occ got=%0d exp=1", c_occ); end
    endtask

    task automatic test_reset_mid();
        a_dn.ready = 1'b0;
        send_a(8'h51);
        tick();
        send_a(8'h52);
        tick();
        a_up.valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        cmps++; if (a_dn.valid !== 1'b0) begin errs++; $display("FAIL rstmid_valid got=%0h exp=0", a_dn.valid); end
        cmps++; if (a_occ !== 2'd0) begin errs++; $display("FAIL rstmid_occ got=%0d exp=0", a_occ); end
        cmps++; if (a_dn.ctrl !== '0) begin errs++; $display("FAIL rstmid_ctrl got=%0h exp=0", a_dn.ctrl); end
        cmps++; if (a_dn.data !== '0) begin errs++; $display("FAIL rstmid_data got=%0h exp=0", a_dn.data); end
        cmps++; if (a_up.ready !== 1'b1) begin errs++; $display("FAIL rstmid_in_ready got=%0h exp=1", a_up.ready); end
        cmps++; if (a_cnt !== 16'd0) begin errs++; $display("FAIL rstmid_cnt got=%0d exp=0", a_cnt); end
        cmps++; if (c_cnt !== 4'd0) begin errs++; $display("FAIL rstmid_c_cnt got=%0d exp=0", c_cnt); end
        #2;
        rst_n = 1'b1;
        tick();
        cmps++; if (a_dn.valid !== 1'b0) begin errs++; $display("FAIL rstmid_after got=%0h exp=0", a_dn.valid); end
    endtask

    initial begin
        cmps       = 0;
        errs       = 0;
        rst_n      = 1'b0;
        flush      = 1'b0;
        a_up.valid = 1'b0; a_up.data = '0; a_up.ctrl = '0; a_dn.ready = 1'b0;
        b_up.valid = 1'b0; b_up.data = '0; b_up.ctrl = '0; b_dn.ready = 1'b0;
        c_up.valid = 1'b0; c_up.data = '0; c_up.ctrl = '0; c_dn.ready = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_skid0();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

endmodule
